// File: rtl/dbf_tx_pkg.sv
// dbf_tx_pkg: shared widths and FSM state encoding for the per-channel transmit beamformer
package dbf_tx_pkg;
    localparam int ADDR_WD = 7;
    localparam int DLY_WD = 12;
    localparam int HP_WD = 6;
    localparam int NCYC_WD = 4;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_DELAY = 3'd2;
    localparam logic [2:0] S_POS = 3'd3;
    localparam logic [2:0] S_NEG = 3'd4;
    localparam logic [2:0] S_FIN = 3'd5;
    localparam logic [2:0] S_DEAD = 3'd6;
    typedef enum logic [2:0] {
        IDLE = S_IDLE, LOAD = S_LOAD, DELAY = S_DELAY,
        POS = S_POS, NEG = S_NEG, FIN = S_FIN, DEAD = S_DEAD
    } state_t;
endpackage

// File: rtl/dbf_tx_ch_if.sv
// dbf_tx_ch_if: trigger, delay-LUT and pulser-drive bundle of one transmit channel
interface dbf_tx_ch_if #(
    parameter int ADDR_WD = dbf_tx_pkg::ADDR_WD,
    parameter int DLY_WD = dbf_tx_pkg::DLY_WD,
    parameter int HP_WD = dbf_tx_pkg::HP_WD,
    parameter int NCYC_WD = dbf_tx_pkg::NCYC_WD
);
    logic start;
    logic abort;
    logic [ADDR_WD-1:0] lut_addr;
    logic [DLY_WD-1:0] lut_din;
    logic lut_we;
    logic [HP_WD-1:0] half_period;
    logic [NCYC_WD-1:0] num_cycles;
    logic tx_p;
    logic tx_n;
    logic tx_en;
    logic tx_done;
    modport master (
        output start, abort, lut_addr, lut_din, lut_we, half_period, num_cycles,
        input tx_p, tx_n, tx_en, tx_done
    );
    modport slave (
        input start, abort, lut_addr, lut_din, lut_we, half_period, num_cycles,
        output tx_p, tx_n, tx_en, tx_done
    );
endinterface

// File: rtl/tx_delay_lut.sv
// tx_delay_lut: focal delay RAM with synchronous write and read-before-write registered read
module tx_delay_lut #(
    parameter int ADDR_WD = dbf_tx_pkg::ADDR_WD,
    parameter int DLY_WD = dbf_tx_pkg::DLY_WD
) (
    input logic clk,
    input logic we,
    input logic [ADDR_WD-1:0] addr,
    input logic [DLY_WD-1:0] din,
    output logic [DLY_WD-1:0] dout
);
    logic [DLY_WD-1:0] mem [2**ADDR_WD];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
        dout <= mem[addr];
    end
endmodule

// File: rtl/dbf_tx_ch.sv
// dbf_tx_ch: per-channel transmit beamformer, focal delay then bipolar burst; TX_DEADTIME_EN adds a 1-clock gap between drive phases
module dbf_tx_ch #(
    parameter int ADDR_WD = dbf_tx_pkg::ADDR_WD,
    parameter int DLY_WD = dbf_tx_pkg::DLY_WD,
    parameter int HP_WD = dbf_tx_pkg::HP_WD,
    parameter int NCYC_WD = dbf_tx_pkg::NCYC_WD
) (
    input logic clk,
    input logic rst,
    dbf_tx_ch_if.slave bus
);
    import dbf_tx_pkg::*;
    state_t st;
    logic [DLY_WD-1:0] rd;
    logic [DLY_WD-1:0] dly;
    logic [HP_WD-1:0] hp;
    logic [HP_WD-1:0] hc;
    logic [NCYC_WD-1:0] nc;
    logic [NCYC_WD-1:0] cc;
    logic tx_p, tx_n, tx_en, tx_done;
`ifdef TX_DEADTIME_EN
    logic nxt_neg;
`endif
    tx_delay_lut #(.ADDR_WD(ADDR_WD), .DLY_WD(DLY_WD)) u_lut (
        .clk(clk), .we(bus.lut_we), .addr(bus.lut_addr), .din(bus.lut_din), .dout(rd)
    );
    assign bus.tx_p = tx_p;
    assign bus.tx_n = tx_n;
    assign bus.tx_en = tx_en;
    assign bus.tx_done = tx_done;
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            {tx_p, tx_n, tx_en, tx_done} <= '0;
            dly <= '0;
            hp <= '0;
            hc <= '0;
            nc <= '0;
            cc <= '0;
`ifdef TX_DEADTIME_EN
            nxt_neg <= 1'b0;
`endif
        end else if (bus.abort && st != IDLE && st != FIN) begin
            st <= FIN;
            {tx_p, tx_n, tx_en, tx_done} <= 4'b0001;
        end else begin
            case (st)
                IDLE: if (bus.start) begin
                    st <= LOAD;
                    tx_en <= 1'b1;
                    hp <= (bus.half_period == '0) ? HP_WD'(1) : bus.half_period;
                    nc <= bus.num_cycles;
                    cc <= '0;
                    hc <= '0;
                end
                LOAD: begin
                    dly <= rd;
                    st <= DELAY;
                end
                DELAY: if (dly != '0) dly <= dly - 1'b1;
                else if (nc == '0) begin
                    st <= FIN;
                    {tx_en, tx_done} <= 2'b01;
                end else begin
                    st <= POS;
                    tx_p <= 1'b1;
                    hc <= '0;
                end
                POS: if (hc != hp - 1'b1) hc <= hc + 1'b1;
                else begin
                    hc <= '0;
                    tx_p <= 1'b0;
`ifdef TX_DEADTIME_EN
                    st <= DEAD;
                    nxt_neg <= 1'b1;
`else
                    st <= NEG;
                    tx_n <= 1'b1;
`endif
                end
                NEG: if (hc != hp - 1'b1) hc <= hc + 1'b1;
                else begin
                    hc <= '0;
                    tx_n <= 1'b0;
                    if (cc == nc - 1'b1) begin
                        st <= FIN;
                        {tx_en, tx_done} <= 2'b01;
                    end else begin
                        cc <= cc + 1'b1;
`ifdef TX_DEADTIME_EN
                        st <= DEAD;
                        nxt_neg <= 1'b0;
`else
                        st <= POS;
                        tx_p <= 1'b1;
`endif
                    end
                end
`ifdef TX_DEADTIME_EN
                DEAD: begin
                    st <= nxt_neg ? NEG : POS;
                    tx_n <= nxt_neg;
                    tx_p <= !nxt_neg;
                end
`endif
                FIN: begin
                    tx_done <= 1'b0;
                    st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dbf_tx_ch.sv
// tb_dbf_tx_ch: directed and random firings checked cycle by cycle against a timing-formula model
module tb_dbf_tx_ch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int lut_m [128];
    int pass_n = 0;
    int tot_n = 0;
    always #5 clk = ~clk;
    dbf_tx_ch_if bus ();
    dbf_tx_ch dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
        tot_n++;
        assert (obs === exp) pass_n++;
        else $error("FAIL %s observed {p,n,en,done}=%b expected=%b", tag, obs, exp);
    endtask

    function automatic logic [3:0] outs();
        return {bus.tx_p, bus.tx_n, bus.tx_en, bus.tx_done};
    endfunction

    // Cycle (relative to start in cycle 0) on which tx_done pulses
    function automatic int ecyc(int d, int h, int n);
        int he = (h == 0) ? 1 : h;
        int e = 3 + d + 2 * he * n;
`ifdef TX_DEADTIME_EN
        if (n > 0) e += 2 * n - 1;
`endif
        return e;
    endfunction

    // Expected {tx_p,tx_n,tx_en,tx_done} at cycle k; ka is the abort cycle (0 = none)
    function automatic logic [3:0] expv(int k, int d, int h, int n, int ka);
        int he = (h == 0) ? 1 : h;
        int dt = 0;
        int e = ecyc(d, h, n);
        int t = k - 3 - d;
        int ph;
`ifdef TX_DEADTIME_EN
        dt = 1;
`endif
        if (ka > 0 && k > ka) return (k == ka + 1) ? 4'b0001 : 4'b0000;
        if (k == e) return 4'b0001;
        if (k < 1 || k > e) return 4'b0000;
        if (n == 0 || t < 0) return 4'b0010;
        ph = t % (2 * he + 2 * dt);
        if (ph < he) return 4'b1010;
        if (ph >= he + dt && ph < 2 * he + dt) return 4'b0110;
        return 4'b0010;
    endfunction

    task automatic wr(int a, int v);
        bus.lut_we = 1'b1;
        bus.lut_addr = 7'(a);
        bus.lut_din = 12'(v);
        tick();
        bus.lut_we = 1'b0;
        lut_m[a] = v;
    endtask

    // One firing; a second start is pulsed in cycle 2, a LUT write to the same entry in cycle wr_k (-1 = none)
    task automatic fire(int a, int h, int n, int ka, int wr_k, int wv);
        int d = lut_m[a];
        int last = (ka > 0) ? ka + 2 : ecyc(d, h, n) + 1;
        bus.lut_addr = 7'(a);
        bus.half_period = 6'(h);
        bus.num_cycles = 4'(n);
        bus.start = 1'b1;
        if (wr_k == 0) begin
            bus.lut_we = 1'b1;
            bus.lut_din = 12'(wv);
            lut_m[a] = wv;
        end
        tick();
        bus.lut_we = 1'b0;
        for (int k = 1; k <= last; k++) begin
            chk($sformatf("fire a=%0d d=%0d h=%0d n=%0d ka=%0d k=%0d", a, d, h, n, ka, k), outs(), expv(k, d, h, n, ka));
            bus.start = (k == 2);
            bus.abort = (k == ka);
            bus.lut_we = (k == wr_k);
            bus.lut_din = 12'(wv);
            if (k == wr_k) lut_m[a] = wv;
            tick();
        end
        {bus.start, bus.abort, bus.lut_we} = '0;
    endtask

    initial begin
        int a, h, n, e, ka, wk;
        {bus.start, bus.abort, bus.lut_we} = '0;
        bus.lut_addr = '0;
        bus.lut_din = '0;
        bus.half_period = '0;
        bus.num_cycles = '0;
        repeat (3) tick();
        chk("reset", outs(), 4'b0000);
        rst = 1'b0;
        tick();
        chk("idle_after_reset", outs(), 4'b0000);
        for (int i = 0; i < 128; i++) wr(i, int'($urandom_range(0, 30)));
        wr(5, 10);
        wr(0, 0);
        wr(9, 4);
        wr(7, 4095);
        fire(5, 2, 3, 0, -1, 0);
        fire(0, 1, 1, 0, -1, 0);
        fire(9, 2, 0, 0, -1, 0);
        fire(9, 4, 2, 8, -1, 0);
        fire(5, 2, 1, 0, 4, 20);
        fire(5, 1, 1, 0, -1, 0);
        fire(0, 1, 1, 0, 0, 7);
        fire(0, 1, 1, 0, -1, 0);
        fire(3, 0, 2, 0, -1, 0);
        fire(1, 1, 15, 0, -1, 0);
        fire(7, 1, 1, 0, -1, 0);
        bus.lut_addr = 7'd5;
        bus.half_period = 6'd2;
        bus.num_cycles = 4'd2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("pre_rst k=%0d", k), outs(), expv(k, 20, 2, 2, 0));
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_delay", outs(), 4'b0000);
        for (int k = 0; k < 30; k++) begin
            tick();
            chk($sformatf("no_done_after_rst k=%0d", k), outs(), 4'b0000);
        end
        for (int r = 0; r < 30; r++) begin
            a = int'($urandom_range(0, 127));
            h = int'($urandom_range(0, 5));
            n = int'($urandom_range(0, 4));
            e = ecyc(lut_m[a], h, n);
            ka = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, e - 1)) : 0;
            wk = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, e)) : -1;
            fire(a, h, n, ka, wk, int'($urandom_range(0, 30)));
        end
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule

// File: doc/dbf_tx_ch.md
Name: dbf_tx_ch

Overview:
- Per-channel transmit beamformer: on a firing trigger, reads this channel's focal delay from a writable delay LUT, waits that many clocks, then drives a bipolar burst (tx_p / tx_n) to the pulser.
- Transmit counterpart of the per-channel receive DBF path. Its tx_en output is the same tx_en that gates receive coarse-delay sample capture.
- One instance per channel under the transmit top. All channels share start and the LUT address and write buses.

Parameters:
- ADDR_WD, 7, LUT address width; depth is 2**ADDR_WD.
- DLY_WD, 12, focal delay width in clk ticks.
- HP_WD, 6, half-period count width.
- NCYC_WD, 4, burst cycle count width.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  firing trigger, single-cycle pulse.
- abort  input  1  stop the burst immediately.
- lut_addr  input  ADDR_WD  LUT address; focal zone select on read, entry select on write.
- lut_din  input  DLY_WD  LUT write data.
- lut_we  input  1  LUT write enable.
- half_period  input  HP_WD  clocks per burst half-cycle; 0 is treated as 1.
- num_cycles  input  NCYC_WD  full cycles per burst; 0 means no burst.
- tx_p  output  1  positive pulser drive.
- tx_n  output  1  negative pulser drive.
- tx_en  output  1  high from the start acceptance to the end of the burst.
- tx_done  output  1  one-cycle pulse when the sequence ends.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters cleared. LUT contents are not reset.
- LUT
  - Single-port RAM, synchronous write, 1-cycle registered read at lut_addr.
  - Writes are legal in any state. A firing in progress uses its latched delay, so a write affects only later firings.
  - With lut_we=1 and start=1 in the same cycle, the write completes and the read returns the old data.
- FSM states: IDLE, LOAD, DELAY, POS, NEG, FIN.
  - IDLE: start=1 moves to LOAD. In the same cycle, half_period and num_cycles are latched and tx_en is set to 1 (registered). start in any other state is ignored.
  - LOAD: the LUT read data is latched into the delay counter. Next state is DELAY.
  - DELAY: the counter decrements each cycle. At 0 the next state is POS, or FIN if num_cycles=0.
  - POS: tx_p=1 for half_period clocks, then NEG.
  - NEG: tx_n=1 for half_period clocks. Then the cycle count increments; the next state is POS if cycles remain, else FIN.
  - FIN: tx_en=0 and tx_done=1 for exactly one cycle, then IDLE.
- Latency: start at cycle 0, with LUT value D and half_period H:
  - tx_p first high at cycle 3+D.
  - tx_en falls and tx_done pulses at cycle 3+D+2·H·N, where N = num_cycles.
  - D=0 gives tx_p at cycle 3.
- Outputs:
  - tx_p and tx_n are registered and never both 1. Both are 0 outside POS and NEG.
  - tx_p and tx_n are 1 throughout POS and NEG respectively, with no gaps.
- abort:
  - Checked in any non-IDLE state, with priority over all FSM transitions. It drives tx_p=tx_n=0 on the next clock and goes to FIN.
  - In IDLE, abort is ignored.
- rst mid-burst: all outputs are 0 on the next edge and tx_done is not pulsed.
- Counters saturate, never wrap.
  - Delay counter width is DLY_WD; the maximum D=2**DLY_WD−1 is honoured exactly.

Optional Feature:
- Macro: TX_DEADTIME_EN.
- When defined: a DEAD state of 1 clock with tx_p=tx_n=0 is inserted between every POS→NEG and NEG→POS transition. No dead time is added before the first POS or after the last NEG.
  - End latency becomes 3+D+2·H·N+(2N−1) for N≥1.
- When undefined: POS and NEG are directly adjacent, per the timing above.

Decomposition:
- Shared package dbf_tx_pkg:
  - FSM state encoding (3-bit localparams).
  - Default widths: ADDR_WD, DLY_WD, HP_WD, NCYC_WD.
- One sub-module: tx_delay_lut, holding the RAM and registered read. It is also reusable by the transmit top for readback and debug.

Test Plan:
- Write LUT[5]=10; set lut_addr=5, H=2, N=3; pulse start.
  - tx_p high at cycles 13–14, 17–18, 21–22.
  - tx_n high at cycles 15–16, 19–20, 23–24.
  - tx_done at cycle 25; tx_en high on cycles 1–24.
- LUT[0]=0, H=1, N=1, start.
  - tx_p at cycle 3, tx_n at cycle 4, tx_done at cycle 5.
- N=0, LUT value 4, start.
  - No tx_p or tx_n activity; tx_done at cycle 7.
- Abort at the 2nd POS cycle of a burst with H=4, N=2.
  - Drives are 0 on the next cycle, tx_done follows, FSM returns to IDLE.
  - A second start during the burst is ignored.
- Write LUT[5]=20 during a firing that used value 10.
  - The current burst keeps D=10; the next firing uses D=20.
  - rst asserted mid-DELAY clears all outputs with no tx_done.
- TX_DEADTIME_EN defined, H=1, N=2, D=0.
  - tx_p at cycles 3 and 7, tx_n at cycles 5 and 9, drives 0 at cycles 4, 6 and 8; tx_done at cycle 10.
